// File: rtl/piso_8bit_tx.sv
// Parallel-in/serial-out transmitter: accepts a word on a valid/ready handshake
// and shifts it out bit by bit, each bit held for CLK_DIV clock cycles.
module piso_8bit_tx #(
  parameter int WIDTH     = 8,
  parameter int CLK_DIV   = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wdata,
  input  logic             wvalid,
  output logic             wready,
  output logic             sdata,
  output logic             sframe,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               sdata_q, sdata_d;
  logic               sframe_q, sframe_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      sdata_q   <= 1'b0;
      sframe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      sdata_q   <= sdata_d;
      sframe_q  <= sframe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Serial outputs are registered, so each is computed one cycle ahead from the
  // value the shift register is about to hold.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    sdata_d   = sdata_q;
    sframe_d  = sframe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        sdata_d  = 1'b0;
        sframe_d = 1'b0;
        busy_d   = 1'b0;
        if (wvalid) begin
          state_d   = SHIFT;
          shreg_d   = wdata;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          sdata_d   = first_bit(wdata);
          sframe_d  = 1'b1;
          busy_d    = 1'b1;
        end
      end
      SHIFT: begin
        if (div_cnt_q == LAST_DIV) begin
          div_cnt_d = '0;
          if (bit_cnt_q == LAST_BIT) begin
            state_d  = DONE;
            sdata_d  = 1'b0;
            sframe_d = 1'b0;
            done_d   = 1'b1;
          end else begin
            shreg_d   = shift_one(shreg_q);
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            sdata_d   = first_bit(shreg_d);
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wready = (state_q == IDLE);
  assign sdata  = sdata_q;
  assign sframe = sframe_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
